// File: rtl/rr_arb32_pkg.sv
// Shared constants and helpers for the 32-way round-robin arbiter.
package rr_arb32_pkg;
    localparam int NUM_REQ   = 32;
    localparam int REQ_IDX_W = 5;

    typedef logic [REQ_IDX_W-1:0] req_idx_t;

    // Pointer advance after a grant; natural 5-bit wrap takes 31 back to 0.
    function automatic req_idx_t next_ptr(input req_idx_t idx);
        return idx + req_idx_t'(1);
    endfunction
endpackage

// File: rtl/mux32.sv
// Generic 32:1 payload select.
module mux32 #(
    parameter int WIDTH = 32
) (
    input  logic [31:0][WIDTH-1:0] ins,
    input  logic [4:0]             sel,
    output logic [WIDTH-1:0]       out
);
    assign out = ins[sel];
endmodule

// File: rtl/rr_pick32.sv
// Combinational round-robin pick: first set request at or after ptr, circularly.
module rr_pick32
    import rr_arb32_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_idx_t           ptr,
    output req_idx_t           idx,
    output logic               any
);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    req_idx_t             off;

    // Rotate right so that bit 0 of rot corresponds to requester ptr.
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[NUM_REQ-1:0];

    always_comb begin
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = req_idx_t'(i);
        end
    end

    assign idx = off + ptr;
    assign any = |req;
endmodule

// File: rtl/rr_arb32.sv
// Round-robin arbiter over 32 requesters feeding a one-entry valid/ready output register.
module rr_arb32
    import rr_arb32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0][WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    output logic [REQ_IDX_W-1:0]         out_src,
    input  logic                         out_ready
);
    req_idx_t         ptr_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    req_idx_t         out_src_reg;

    req_idx_t         win_idx;
    logic             any;
    logic             load;
    logic             grant;
    logic [WIDTH-1:0] mux_out;

    rr_pick32 u_pick (
        .req (req_valid),
        .ptr (ptr_reg),
        .idx (win_idx),
        .any (any)
    );

    mux32 #(.WIDTH(WIDTH)) u_mux (
        .ins (req_data),
        .sel (win_idx),
        .out (mux_out)
    );

    // Register is free when empty or being drained in this same cycle.
    assign load  = ~out_valid_reg | out_ready;
    assign grant = load & any & ~rst;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant & (win_idx == req_idx_t'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_src_reg   <= '0;
        end else if (load) begin
            if (any) begin
                out_data_reg  <= mux_out;
                out_src_reg   <= win_idx;
                out_valid_reg <= 1'b1;
                ptr_reg       <= next_ptr(win_idx);
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_src   = out_src_reg;
endmodule

// File: tb/tb_rr_arb32.sv
// Randomized and directed checks of rr_arb32 against a behavioural arbitration model.
module tb_rr_arb32;
    localparam int W = 32;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [31:0]           req_valid = '0;
    logic [31:0][W-1:0]    req_data = '0;
    logic [31:0]           req_ready;
    logic                  out_valid;
    logic [W-1:0]          out_data;
    logic [4:0]            out_src;
    logic                  out_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    // Model state
    int       m_ptr = 0;
    bit       m_valid = 0;
    logic [W-1:0] m_data = '0;
    int       m_src = 0;
    bit       last_grant = 0;
    int       last_g = 0;

    // Random-phase requester bookkeeping
    bit           fair_en = 0;
    bit           pending [32];
    logic [W-1:0] pdata [32];
    int           wait_cnt [32];

    always #5 clk = ~clk;

    rr_arb32 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called just after inputs are driven: compare, then advance the model across the next edge.
    task automatic step();
        int g;
        bit any_m, load_m, do_grant;
        logic [31:0] exp_rr;
        #1;
        any_m = 0;
        g = 0;
        for (int k = 0; k < 32; k++) begin
            if (!any_m && req_valid[(m_ptr + k) % 32]) begin
                any_m = 1;
                g = (m_ptr + k) % 32;
            end
        end
        load_m = !m_valid || out_ready;
        do_grant = !rst && load_m && any_m;
        exp_rr = do_grant ? (32'd1 << g) : 32'd0;
        check("req_ready", 64'(req_ready), 64'(exp_rr));
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_data", 64'(out_data), 64'(m_data));
        check("out_src", 64'(out_src), 64'(m_src));
        $display("cyc t=%0t rst=%0b rv=%08h ordy=%0b grant=%0b g=%0d ov=%0b src=%0d data=%08h",
                 $time, rst, req_valid, out_ready, do_grant, g, out_valid, out_src, out_data);
        last_grant = do_grant;
        last_g = g;
        if (fair_en && do_grant) begin
            check("fair_wait", 64'(wait_cnt[g] < 32), 64'd1);
            for (int i = 0; i < 32; i++)
                if (pending[i] && i != g) wait_cnt[i]++;
            wait_cnt[g] = 0;
        end
        if (rst) begin
            m_ptr = 0; m_valid = 0; m_data = '0; m_src = 0;
        end else if (load_m) begin
            if (any_m) begin
                m_data = req_data[g];
                m_src = g;
                m_valid = 1;
                m_ptr = (g + 1) % 32;
            end else begin
                m_valid = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit r, input logic [31:0] v, input bit ordy);
        rst = r;
        req_valid = v;
        out_ready = ordy;
        step();
    endtask

    initial begin
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 32; i++) req_data[i] = W'(i + 100);

        // Reset then idle.
        drive(1, '0, 1);
        for (int c = 0; c < 3; c++) drive(0, '0, 1);

        // All requesters valid: full rotation plus wrap.
        for (int c = 0; c < 34; c++) drive(0, '1, 1);

        // Only 5 and 30: alternation.
        for (int c = 0; c < 6; c++) drive(0, (32'd1 << 5) | (32'd1 << 30), 1);

        // Load src 7, then backpressure with 3 and 9 valid.
        drive(0, '0, 1);
        drive(0, 32'd1 << 7, 1);
        for (int c = 0; c < 4; c++) drive(0, (32'd1 << 3) | (32'd1 << 9), 0);
        drive(0, (32'd1 << 3) | (32'd1 << 9), 1);

        // Single requester 31 continuously.
        for (int c = 0; c < 5; c++) drive(0, 32'd1 << 31, 1);

        // Reset while holding a stalled entry.
        drive(0, 32'd1 << 12, 0);
        drive(1, 32'd1 << 12, 0);
        drive(0, '0, 1);
        drive(0, '0, 1);

        // Randomized traffic respecting the hold-until-granted rule.
        for (int i = 0; i < 32; i++) begin
            pending[i] = 0;
            wait_cnt[i] = 0;
        end
        fair_en = 1;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 32; i++) begin
                if (!pending[i] && $urandom_range(0, 3) == 0) begin
                    pending[i] = 1;
                    pdata[i] = W'($urandom);
                    wait_cnt[i] = 0;
                end
                req_data[i] = pdata[i];
            end
            for (int i = 0; i < 32; i++) req_valid[i] = pending[i];
            out_ready = ($urandom_range(0, 3) != 0);
            rst = 0;
            step();
            if (last_grant) pending[last_g] = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
